sample_framer: RTL and testbench
================================

SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 SHALL have parameter FFT_POINTS, default 16, giving the frame length in samples (power of two, >=4).
REQ-002 SHALL have parameter DATA_WIDTH, default 24, giving the real sample width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_sample  input  DATA_WIDTH  incoming real sample.
REQ-006 SHALL have port in_valid  input  1  in_sample valid.
REQ-007 SHALL have port in_ready  output  1  framer can accept a sample this cycle.
REQ-008 SHALL have port fft_in_prog  input  1  busy flag from the downstream FFT controller.
REQ-009 SHALL have port start_fft  output  1  one-cycle launch pulse to the FFT controller.
REQ-010 SHALL have port frame_data  output  DATA_WIDTH x FFT_POINTS (unpacked [0:FFT_POINTS-1])  frame presented with start_fft.
REQ-011 SHALL have port overflow  output  1  sticky flag; upstream offered data while in_ready was low.
REQ-012 SHALL have port frame_count  output  16  number of frames launched, wrapping modulo 2^16.

Function
REQ-013 SHALL hold two sample banks (0/1), each FFT_POINTS x DATA_WIDTH, with per-bank pending flags, write bank pointer wr_bank, write index wr_idx, and read bank pointer rd_bank.
REQ-014 SHALL drive in_ready combinationally as reset_n AND NOT pending[wr_bank].
REQ-015 SHALL accept a sample on in_valid AND in_ready: bank[wr_bank][wr_idx] <= in_sample; wr_idx increments.
REQ-016 SHALL, on accepting the sample at wr_idx == FFT_POINTS-1, set pending[wr_bank], toggle wr_bank, and set wr_idx to 0 on the same edge.
REQ-017 SHALL implement FSM states IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE -> START when pending[rd_bank] AND NOT fft_in_prog; on this edge frame_data <= bank[rd_bank].
REQ-019 START: start_fft = 1 for exactly this cycle; on exit, clear pending[rd_bank], toggle rd_bank, increment frame_count, and go to WAIT_ACK.
REQ-020 WAIT_ACK -> WAIT_DONE when fft_in_prog = 1; otherwise remain in WAIT_ACK.
REQ-021 WAIT_DONE -> IDLE when fft_in_prog = 0; otherwise remain in WAIT_DONE.
REQ-022 SHALL hold frame_data stable from START until the next IDLE->START transition.
REQ-023 Latency: with the FSM in IDLE and fft_in_prog low, start_fft SHALL assert in the 2nd cycle after the cycle that accepted the frame's last sample.
REQ-024 If a pending-set on one bank and a pending-clear on the other occur on the same edge, both SHALL take effect.
REQ-025 When both banks are pending, in_ready SHALL be 0 and no sample SHALL be written or lost.
REQ-026 SHALL set overflow when in_valid = 1 AND in_ready = 0 while reset_n is high; overflow is cleared only by reset.
REQ-027 SHALL keep sample order within and across frames: frame k contains samples k*FFT_POINTS .. k*FFT_POINTS+FFT_POINTS-1 in index order.

Reset
REQ-028 While reset_n = 0 at a clock edge, the block SHALL apply: FSM IDLE, wr_bank = rd_bank = 0, wr_idx = 0, pending cleared, start_fft = 0, frame_data = 0, overflow = 0, frame_count = 0; bank contents are not reset.
REQ-029 Reset mid-frame or mid-handshake SHALL discard partial and pending frames; the next accepted sample is index 0 of bank 0.

Structure
REQ-030 SHALL place the FFT_POINTS and DATA_WIDTH defaults and the FSM state enum in shared package fft_pkg.
REQ-031 SHALL implement each bank as one instance of sub-module sample_bank (write port, full-width parallel read), instantiated twice.

Verification
REQ-032 Reset, then feed samples 1..16 back-to-back with fft_in_prog = 0 -> one start_fft pulse 2 cycles after sample 16; frame_data[0..15] = 1..16; frame_count = 1.
REQ-033 Hold fft_in_prog = 1 while feeding 48 samples -> in_ready drops after sample 32; overflow = 1 only if in_valid stays high; on release, frames 1..16 and 17..32 launch in order.
REQ-034 After a launch, keep fft_in_prog = 0 for 20 cycles -> FSM stays in WAIT_ACK; no second start_fft, even with bank 1 pending.
REQ-035 Assert reset_n = 0 after sample 7 of a frame, then feed 101..116 -> first frame_data = 101..116; overflow = 0; frame_count = 1.
REQ-036 Stream 65536 + 2 frames against a model FFT with 10-cycle busy -> frame_count wraps to 2; no sample loss or reordering.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and FSM encoding for the sample framer and its banks.
package fft_pkg;

  localparam int unsigned FFT_POINTS_DEFAULT = 16;
  localparam int unsigned DATA_WIDTH_DEFAULT = 24;
  localparam int unsigned FRAME_COUNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } fsm_state_e;

endpackage : fft_pkg

// File: rtl/sample_bank.sv
// One frame buffer: single write port, every entry visible in parallel.
module sample_bank
  import fft_pkg::*;
#(
  parameter int unsigned N = FFT_POINTS_DEFAULT,
  parameter int unsigned W = DATA_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] waddr_i,
  input  logic [W-1:0]         wdata_i,
  output logic [W-1:0]         rdata_o [0:N-1]
);

  // Storage is deliberately not reset; a frame is only read once fully written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      rdata_o[waddr_i] <= wdata_i;
    end
  end

endmodule : sample_bank

// File: rtl/sample_framer.sv
// Ping-pong framer: collects FFT_POINTS samples per bank and launches full
// frames to a downstream FFT controller with a start/busy handshake.
module sample_framer
  import fft_pkg::*;
#(
  parameter int unsigned FFT_POINTS = FFT_POINTS_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    in_sample,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     fft_in_prog,
  output logic                     start_fft,
  output logic [DATA_WIDTH-1:0]    frame_data [0:FFT_POINTS-1],
  output logic                     overflow,
  output logic [FRAME_COUNT_W-1:0] frame_count
);

  localparam int unsigned IDX_W = $clog2(FFT_POINTS);

  fsm_state_e               state_q, state_d;
  logic [1:0]               pending_q, pending_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic                     start_fft_q, start_fft_d;
  logic                     overflow_q, overflow_d;
  logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0]    frame_q [0:FFT_POINTS-1];
  logic [DATA_WIDTH-1:0]    bank0_rd [0:FFT_POINTS-1];
  logic [DATA_WIDTH-1:0]    bank1_rd [0:FFT_POINTS-1];
  logic                     accept_c;
  logic                     load_frame_c;

  assign in_ready = reset_n & ~pending_q[wr_bank_q];
  assign accept_c = in_valid & in_ready;

  sample_bank #(.N(FFT_POINTS), .W(DATA_WIDTH)) u_bank0 (
    .clk     (clk),
    .we_i    (accept_c & ~wr_bank_q),
    .waddr_i (wr_idx_q),
    .wdata_i (in_sample),
    .rdata_o (bank0_rd)
  );

  sample_bank #(.N(FFT_POINTS), .W(DATA_WIDTH)) u_bank1 (
    .clk     (clk),
    .we_i    (accept_c & wr_bank_q),
    .waddr_i (wr_idx_q),
    .wdata_i (in_sample),
    .rdata_o (bank1_rd)
  );

  // Write-side bookkeeping and launch FSM next-state.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_idx_d      = wr_idx_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q | (in_valid & ~in_ready);
    load_frame_c  = 1'b0;

    if (accept_c) begin
      if (wr_idx_q == IDX_W'(FFT_POINTS - 1)) begin
        pending_d[wr_bank_q] = 1'b1;
        wr_bank_d            = ~wr_bank_q;
        wr_idx_d             = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    // A set on the write bank and a clear on the read bank never target the
    // same bank: the write bank is only writable while it is not pending.
    case (state_q)
      IDLE: begin
        if (pending_q[rd_bank_q] && !fft_in_prog) begin
          state_d      = START;
          load_frame_c = 1'b1;
        end
      end
      START: begin
        pending_d[rd_bank_q] = 1'b0;
        rd_bank_d            = ~rd_bank_q;
        frame_count_d        = frame_count_q + FRAME_COUNT_W'(1);
        state_d              = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (fft_in_prog) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!fft_in_prog) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_fft_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      start_fft_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      start_fft_q   <= start_fft_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Snapshot of the launched bank, held until the next launch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FFT_POINTS; i++) frame_q[i] <= '0;
    end else if (load_frame_c) begin
      for (int unsigned i = 0; i < FFT_POINTS; i++) begin
        frame_q[i] <= rd_bank_q ? bank1_rd[i] : bank0_rd[i];
      end
    end
  end

  assign start_fft   = start_fft_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;
  assign frame_data  = frame_q;

endmodule : sample_framer

// File: tb/tb_sample_framer.sv
// Self-checking bench for sample_framer: directed vectors plus a randomized
// stream against a frame-level reference model.
module tb_sample_framer;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          in_ready;
  logic          fft_in_prog;
  logic          start_fft;
  logic [DW-1:0] frame_data [0:N-1];
  logic          overflow;
  logic [15:0]   frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  sample_framer #(.FFT_POINTS(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fft_in_prog (fft_in_prog),
    .start_fft   (start_fft),
    .frame_data  (frame_data),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] s;
    logic          f;
    logic          rdy;
    logic          st;
    logic [15:0]   fc;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cyc(input logic v, input logic [DW-1:0] s, input logic f);
    @(negedge clk);
    in_valid    = v;
    in_sample   = s;
    fft_in_prog = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; in_sample = '0; fft_in_prog = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic wait_start(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      #1;
      if (start_fft) found = 1'b1;
    end
    check(name, 64'(found), 64'd1);
  endtask

  task automatic check_frame(input string name, input int base);
    for (int i = 0; i < N; i++) check(name, 64'(frame_data[i]), 64'(base + i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] q [$];
    int            pend, part, launched, accepted, fft_from, fft_to;
    bit            ovf_m, exp_rdy, v, f;
    logic [DW-1:0] s;

    reset_n = 1'b1; in_valid = 1'b0; in_sample = '0; fft_in_prog = 1'b0;

    // Per-cycle vectors for the first frame: 16 samples, launch two cycles later.
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, DW'(i + 1), 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[16] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[17] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 16'd0};
    tbl[18] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 16'd1};

    // Reset values, sampled while reset is still asserted.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_start", 64'(start_fft), 64'd0);
    check("rst_count", 64'(frame_count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_frame0", 64'(frame_data[0]), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // First frame, cycle by cycle.
    for (int r = 0; r < 19; r++) begin
      cyc(tbl[r].v, tbl[r].s, tbl[r].f);
      check($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].rdy));
      check($sformatf("tbl%0d_start", r), 64'(start_fft), 64'(tbl[r].st));
      check($sformatf("tbl%0d_count", r), 64'(frame_count), 64'(tbl[r].fc));
    end
    check_frame("frame1_data", 1);

    // No ack from the FFT: FSM parks, both banks fill, frame stays stable.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, DW'(17 + i), 1'b0);
      check("noack_ready", 64'(in_ready), 64'd1);
      check("noack_start", 64'(start_fft), 64'd0);
    end
    cyc(1'b0, '0, 1'b0);
    check("both_full_ready", 64'(in_ready), 64'd0);
    check("noack_start_end", 64'(start_fft), 64'd0);
    check_frame("frame1_stable", 1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    wait_start("frame2_launch");
    check_frame("frame2_data", 17);
    check("frame2_count_at_start", 64'(frame_count), 64'd1);
    check("ready_during_start", 64'(in_ready), 64'd0);
    cyc(1'b0, '0, 1'b0);
    check("frame2_count_after", 64'(frame_count), 64'd2);
    check("ready_after_start", 64'(in_ready), 64'd1);

    // FFT busy while 32 samples arrive, then a sample offered while not ready.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, DW'(1 + i), 1'b1);
      check("busy_ready", 64'(in_ready), 64'd1);
    end
    cyc(1'b0, '0, 1'b1);
    check("busy_full_ready", 64'(in_ready), 64'd0);
    check("busy_no_ovf", 64'(overflow), 64'd0);
    cyc(1'b1, DW'(33), 1'b1);
    cyc(1'b1, DW'(33), 1'b1);
    check("busy_ovf_set", 64'(overflow), 64'd1);
    cyc(1'b0, '0, 1'b0);
    wait_start("busy_launch1");
    check_frame("busy_frame1", 1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    wait_start("busy_launch2");
    check_frame("busy_frame2", 17);
    check("busy_ovf_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a frame discards the partial data.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(201 + i), 1'b0);
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(101 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    wait_start("midrst_launch");
    check_frame("midrst_frame", 101);
    check("midrst_ovf", 64'(overflow), 64'd0);
    cyc(1'b0, '0, 1'b0);
    check("midrst_count", 64'(frame_count), 64'd1);

    // Randomized stream against a frame-level model and a 10-cycle busy FFT.
    do_reset();
    pend = 0; part = 0; launched = 0; accepted = 0; ovf_m = 1'b0;
    fft_from = -100; fft_to = -100;
    for (int c = 0; c < 4000; c++) begin
      exp_rdy = (pend < 2);
      f = (c >= fft_from) && (c < fft_to);
      if (c >= 3600) v = 1'b0;
      else if (exp_rdy) v = ($urandom_range(0, 3) != 0);
      else v = ($urandom_range(0, 63) == 0);
      s = DW'($urandom());
      cyc(v, s, f);
      check("rnd_ready", 64'(in_ready), 64'(exp_rdy));
      check("rnd_overflow", 64'(overflow), 64'(ovf_m));
      if (start_fft) begin
        check("rnd_start_gap", 64'(c >= fft_to + 2), 64'd1);
        check("rnd_count", 64'(frame_count), 64'(launched[15:0]));
        check("rnd_frame_ready", 64'(q.size() >= N), 64'd1);
        if (q.size() >= N) begin
          for (int i = 0; i < N; i++) check("rnd_frame_data", 64'(frame_data[i]), 64'(q.pop_front()));
        end
        launched++;
        pend--;
        fft_from = c + 1 + int'($urandom_range(0, 3));
        fft_to   = fft_from + 10;
      end
      if (v && exp_rdy) begin
        q.push_back(s);
        accepted++;
        part++;
        if (part == N) begin
          part = 0;
          pend++;
        end
      end
      if (v && !exp_rdy) ovf_m = 1'b1;
    end
    check("rnd_all_launched", 64'(launched), 64'(accepted / N));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sample_framer
